// File: rtl/byte_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer_if
// Description : Bundle of the word handshake and the serial output signals of
//               byte_serializer.
//               master : word source / serial consumer side
//                        (drives din, din_valid, OP)
//               slave  : the serializer itself
//                        (drives din_ready, sdata, shift_en, busy, frame_done)
// Revision    : 1.0 - initial release
// ============================================================================
interface byte_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             OP;
    logic             sdata;
    logic             shift_en;
    logic             busy;
    logic             frame_done;

    modport master (
        output din, din_valid, OP,
        input  din_ready, sdata, shift_en, busy, frame_done
    );

    modport slave (
        input  din, din_valid, OP,
        output din_ready, sdata, shift_en, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Parallel-to-serial source stage. Accepts a WIDTH-bit word over
//               a valid/ready handshake and emits it one bit per DIV-cycle bit
//               period on sdata, MSB-first (OP=1) or LSB-first (OP=0), so a
//               downstream shift register using the same OP ends up holding
//               the original word after WIDTH strobes.
// Ports       : CLK        - rising-edge clock
//               reset      - asynchronous, active-high reset
//               bus.din        (in)  parallel word
//               bus.din_valid  (in)  din/OP valid
//               bus.OP         (in)  direction, 1 = MSB-first
//               bus.din_ready  (out) word can be accepted (IDLE)
//               bus.sdata      (out) serial data bit
//               bus.shift_en   (out) strobe on last cycle of each bit period
//               bus.busy       (out) frame in progress (SHIFT or DONE)
//               bus.frame_done (out) one-cycle pulse after the last bit
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  wire logic         CLK,
    input  wire logic         reset,
    byte_serializer_if.slave  bus
);

    localparam int c_bcw = $clog2(WIDTH);
    localparam int c_dcw = $clog2(DIV) + 1;

    localparam logic [c_bcw-1:0] c_bit_last = c_bcw'(WIDTH - 1);
    localparam logic [c_dcw-1:0] c_div_last = c_dcw'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_buf;
    logic               r_op;
    logic [c_bcw-1:0]   r_bit_cnt;
    logic [c_dcw-1:0]   r_div_cnt;

    logic               w_accept;
    logic               w_strobe;
    logic               w_din_ready;
    logic               w_sdata;
    logic               w_shift_en;
    logic               w_busy;
    logic               w_frame_done;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode. Outputs depend on registered state only;
    // din_valid feeds w_accept, which steers state/datapath but no output.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_strobe     = 1'b0;
        w_din_ready  = 1'b0;
        w_sdata      = 1'b0;
        w_shift_en   = 1'b0;
        w_busy       = 1'b0;
        w_frame_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_din_ready = 1'b1;
                if (bus.din_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end

            S_SHIFT: begin
                w_busy  = 1'b1;
                w_sdata = r_op ? r_buf[WIDTH-1] : r_buf[0];
                if (r_div_cnt == c_div_last) begin
                    w_strobe   = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_bit_last) begin
                        w_next_state = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_busy       = 1'b1;
                w_frame_done = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: shift buffer, latched direction and the two counters.
    // OP and din are sampled only at acceptance, so mid-frame changes on the
    // bus cannot disturb the word being sent.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_buf     <= '0;
            r_op      <= 1'b0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else if (w_accept) begin
            r_buf     <= bus.din;
            r_op      <= bus.OP;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            if (w_strobe) begin
                r_buf     <= r_op ? {r_buf[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_buf[WIDTH-1:1]};
                r_div_cnt <= '0;
                // Hold at the terminal count; the next accept clears it.
                if (r_bit_cnt != c_bit_last) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign bus.din_ready  = w_din_ready;
    assign bus.sdata      = w_sdata;
    assign bus.shift_en   = w_shift_en;
    assign bus.busy       = w_busy;
    assign bus.frame_done = w_frame_done;

endmodule
`default_nettype wire
